// File: rtl/gate74_pkg.sv
// gate74_pkg: shared mode encoding and priority constant for the gate74 shift register family.
// Contents: gate74_mode_e (S encoding), GATE74_PRESET_WINS (PR beats SCLR when both are low).
package gate74_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } gate74_mode_e;
  localparam bit GATE74_PRESET_WINS = 1'b1;
endpackage

// File: rtl/gate74_bit_counter.sv
// gate74_bit_counter: saturating shifts-remaining down-counter with load, sync clear and async clear.
// Ports: CLK clock; CLR async active-low clear; sclr sync clear (active high); load sets CNT to WIDTH;
//        dec decrements unless already zero; CNT count; EMPTY high when CNT is zero.
module gate74_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             sclr,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] CNT,
  output logic             EMPTY
);
  logic [CNT_W-1:0] cnt_nxt;
  always_comb begin
    cnt_nxt = sclr ? '0
            : load ? CNT_W'(WIDTH)
            : (dec && CNT != '0) ? CNT - CNT_W'(1)
            : CNT;
  end
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) CNT <= '0;
    else CNT <= cnt_nxt;
  end
  assign EMPTY = (CNT == '0);
endmodule

// File: rtl/gate74_shift_reg.sv
// gate74_shift_reg: WIDTH-bit universal shift register with 74-series preset/clear priority and shift counter.
// Ports: CLK clock; CLR async active-low reset; PR sync preset (low); SCLR sync clear (low);
//        S mode (00 hold, 01 shift right, 10 shift left, 11 load); DSR/DSL serial inputs; D load data;
//        ROT rotate select (only with GATE74_SHIFT_ROTATE_EN); Q/Qn register and complement;
//        SOR = Q[WIDTH-1]; SOL = Q[0]; CNT shifts remaining since last load; EMPTY when CNT is zero.
// Build option: GATE74_SHIFT_ROTATE_EN adds the ROT port and rotate behaviour.
module gate74_shift_reg
  import gate74_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             PR,
  input  logic             SCLR,
  input  logic [1:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
`ifdef GATE74_SHIFT_ROTATE_EN
  input  logic             ROT,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             SOR,
  output logic             SOL,
  output logic [CNT_W-1:0] CNT,
  output logic             EMPTY
);
  gate74_mode_e     mode;
  logic             shr_in;
  logic             shl_in;
  logic             sync_clr;
  logic [WIDTH-1:0] q_nxt;
  assign mode = gate74_mode_e'(S);
`ifdef GATE74_SHIFT_ROTATE_EN
  // Rotation feeds the bit falling off the far end back in place of the serial input.
  assign shr_in = ROT ? Q[WIDTH-1] : DSR;
  assign shl_in = ROT ? Q[0] : DSL;
`else
  assign shr_in = DSR;
  assign shl_in = DSL;
`endif
  assign sync_clr = !PR || !SCLR;
  always_comb begin
    q_nxt = (!PR && GATE74_PRESET_WINS) ? '1
          : !SCLR ? '0
          : mode == MODE_SHR ? {Q[WIDTH-2:0], shr_in}
          : mode == MODE_SHL ? {shl_in, Q[WIDTH-1:1]}
          : mode == MODE_LOAD ? D
          : Q;
  end
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) Q <= '0;
    else Q <= q_nxt;
  end
  gate74_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .CLK   (CLK),
    .CLR   (CLR),
    .sclr  (sync_clr),
    .load  (mode == MODE_LOAD),
    .dec   (mode == MODE_SHR || mode == MODE_SHL),
    .CNT   (CNT),
    .EMPTY (EMPTY)
  );
  assign Qn  = ~Q;
  assign SOR = Q[WIDTH-1];
  assign SOL = Q[0];
endmodule
